// File: rtl/sd_cmd_rx_if.sv
// SD CMD receive bus: raw SD pins and receive enable in, decoded command token out.
interface sd_cmd_rx_if;
  logic        i_sd_clk;
  logic        i_sd_cmd;
  logic        i_rx_en;
  logic        o_valid;
  logic [5:0]  o_cmd_index;
  logic [31:0] o_arg;
  logic        o_crc_err;
  logic        o_frame_err;
  logic        o_busy;

  modport master (
    output i_sd_clk, i_sd_cmd, i_rx_en,
    input  o_valid, o_cmd_index, o_arg, o_crc_err, o_frame_err, o_busy
  );

  modport slave (
    input  i_sd_clk, i_sd_cmd, i_rx_en,
    output o_valid, o_cmd_index, o_arg, o_crc_err, o_frame_err, o_busy
  );
endinterface

// File: rtl/sd_cmd_rx.sv
// SD command-line receiver: oversamples SD_CLK/CMD, deserialises 48-bit host
// tokens, checks framing and CRC7, and strobes index/argument for one cycle.
module sd_cmd_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  sd_cmd_rx_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // CRC7 (x^7 + x^3 + 1, init 0) over the 40 token bits ahead of the CRC field, MSB first
  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return crc;
  endfunction

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sd_clk_sync_q, sd_clk_sync_d;
  logic [SYNC_STAGES-1:0] sd_cmd_sync_q, sd_cmd_sync_d;
  logic                   sd_clk_prev_q, sd_clk_prev_d;
  logic [47:0]            shift_q, shift_d;
  logic [5:0]             bit_cnt_q, bit_cnt_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic [5:0]             cmd_index_q, cmd_index_d;
  logic [31:0]            arg_q, arg_d;
  logic                   crc_err_q, crc_err_d;
  logic                   frame_err_q, frame_err_d;

  logic                   sd_clk_s;
  logic                   cmd_s;
  logic                   sample_stb;

  // Synchroniser shift and rising-edge detection on the synced SD clock
  always_comb begin
    sd_clk_sync_d = {sd_clk_sync_q[SYNC_STAGES-2:0], bus.i_sd_clk};
    sd_cmd_sync_d = {sd_cmd_sync_q[SYNC_STAGES-2:0], bus.i_sd_cmd};
    sd_clk_s      = sd_clk_sync_q[SYNC_STAGES-1];
    cmd_s         = sd_cmd_sync_q[SYNC_STAGES-1];
    sd_clk_prev_d = sd_clk_s;
    sample_stb    = sd_clk_s & ~sd_clk_prev_q;
  end

  // Receive FSM: next state, shift register, bit counter and output registers
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    valid_d     = 1'b0;
    busy_d      = busy_q;
    cmd_index_d = cmd_index_q;
    arg_d       = arg_q;
    crc_err_d   = crc_err_q;
    frame_err_d = frame_err_q;
    case (state_q)
      ST_IDLE: begin
        if (sample_stb && bus.i_rx_en && !cmd_s) begin
          shift_d   = {shift_q[46:0], cmd_s};
          bit_cnt_d = 6'd1;
          busy_d    = 1'b1;
          state_d   = ST_RECV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECV: begin
        // Dropping receive enable abandons the token without touching the outputs
        if (!bus.i_rx_en) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (sample_stb) begin
          shift_d   = {shift_q[46:0], cmd_s};
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'd47) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_RECV;
          end
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_CHECK: begin
        cmd_index_d = shift_q[45:40];
        arg_d       = shift_q[39:8];
        crc_err_d   = (crc7(shift_q[47:8]) != shift_q[7:1]);
        frame_err_d = ~shift_q[46] | ~shift_q[0];
        valid_d     = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        bit_cnt_d = 6'd0;
        state_d   = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      sd_clk_sync_q <= {SYNC_STAGES{1'b1}};
      sd_cmd_sync_q <= {SYNC_STAGES{1'b1}};
      sd_clk_prev_q <= 1'b1;
      shift_q       <= 48'd0;
      bit_cnt_q     <= 6'd0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      cmd_index_q   <= 6'd0;
      arg_q         <= 32'd0;
      crc_err_q     <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sd_clk_sync_q <= sd_clk_sync_d;
      sd_cmd_sync_q <= sd_cmd_sync_d;
      sd_clk_prev_q <= sd_clk_prev_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
      cmd_index_q   <= cmd_index_d;
      arg_q         <= arg_d;
      crc_err_q     <= crc_err_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign bus.o_valid     = valid_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_cmd_index = cmd_index_q;
  assign bus.o_arg       = arg_q;
  assign bus.o_crc_err   = crc_err_q;
  assign bus.o_frame_err = frame_err_q;

endmodule

// File: tb/tb_sd_cmd_rx.sv
// Bench for sd_cmd_rx: directed SD command tokens plus randomized tokens and
// clock ratios, checked against a polynomial-division reference model.
module tb_sd_cmd_rx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sd_cmd_rx_if bus ();

  sd_cmd_rx #(.SYNC_STAGES(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_valid = 0;
  int last_rise = 0;
  logic prev_valid = 1'b0;
  logic busy_seen  = 1'b0;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        crc;
    logic        frm;
    int          c;
  } rec_t;
  rec_t obs_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Remainder of (message * x^7) divided by x^7 + x^3 + 1
  function automatic logic [6:0] ref_crc(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'd0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] make_token(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] head;
    head = {2'b01, idx, arg};
    return {head, ref_crc(head), 1'b1};
  endfunction

  // Output monitor: records every valid pulse and tracks busy activity
  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_valid === 1'b1) begin
        rec_t r;
        r.idx = bus.o_cmd_index;
        r.arg = bus.o_arg;
        r.crc = bus.o_crc_err;
        r.frm = bus.o_frame_err;
        r.c   = cyc;
        obs_q.push_back(r);
        n_valid++;
        check_eq("valid_width", {63'd0, prev_valid}, 64'd0);
      end
      prev_valid = bus.o_valid;
      if (bus.o_busy === 1'b1) busy_seen = 1'b1;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int h);
    bus.i_sd_cmd = b;
    wait_cyc(h);
    bus.i_sd_clk = 1'b1;
    last_rise = cyc;
    wait_cyc(h);
    bus.i_sd_clk = 1'b0;
  endtask

  task automatic send_token(input logic [47:0] t, input int h, input int nbits);
    for (int i = 47; i > 47 - nbits; i--) send_bit(t[i], h);
  endtask

  task automatic expect_tok(input string tag, input logic [47:0] t, input int end_c);
    int   w;
    rec_t r;
    logic exp_crc;
    logic exp_frm;
    w = 0;
    while (obs_q.size() == 0 && w < 40) begin
      wait_cyc(1);
      w++;
    end
    if (obs_q.size() == 0) begin
      check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      r = obs_q.pop_front();
      exp_crc = (ref_crc(t[47:8]) != t[7:1]);
      exp_frm = ~t[46] | ~t[0];
      check_eq({tag, "_idx"}, {58'd0, r.idx}, {58'd0, t[45:40]});
      check_eq({tag, "_arg"}, {32'd0, r.arg}, {32'd0, t[39:8]});
      check_eq({tag, "_crc_err"}, {63'd0, r.crc}, {63'd0, exp_crc});
      check_eq({tag, "_frame_err"}, {63'd0, r.frm}, {63'd0, exp_frm});
      // End-bit rise -> 2 sync stages -> strobe -> CHECK -> valid
      check_eq({tag, "_latency"}, 64'(r.c - end_c), 64'd4);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, {63'd0, bus.o_valid}, 64'd0);
    check_eq({tag, "_busy"}, {63'd0, bus.o_busy}, 64'd0);
    check_eq({tag, "_idx"}, {58'd0, bus.o_cmd_index}, 64'd0);
    check_eq({tag, "_arg"}, {32'd0, bus.o_arg}, 64'd0);
    check_eq({tag, "_crc_err"}, {63'd0, bus.o_crc_err}, 64'd0);
    check_eq({tag, "_frame_err"}, {63'd0, bus.o_frame_err}, 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [47:0] t;
    int e1, e2, nv, h, mode;
    bus.i_sd_clk = 1'b0;
    bus.i_sd_cmd = 1'b1;
    bus.i_rx_en  = 1'b1;
    rst = 1'b1;
    wait_cyc(3);
    check_all_zero("reset");
    rst = 1'b0;
    wait_cyc(3);

    // CMD0 at i_clk/8
    send_token(48'h400000000095, 4, 48);
    e1 = last_rise;
    expect_tok("cmd0", 48'h400000000095, e1);
    check_eq("cmd0_crc_const", {63'd0, bus.o_crc_err}, 64'd0);

    // CMD8 then CMD17 with one idle SD_CLK between them
    send_token(48'h48000001AA87, 4, 48);
    e1 = last_rise;
    send_bit(1'b1, 4);
    send_token(48'h510000000055, 4, 48);
    e2 = last_rise;
    expect_tok("cmd8", 48'h48000001AA87, e1);
    expect_tok("cmd17", 48'h510000000055, e2);
    check_eq("cmd17_idx_const", {58'd0, bus.o_cmd_index}, 64'd17);

    // Corrupted CRC, then a bad end bit
    send_token(48'h48000001AA89, 4, 48);
    e1 = last_rise;
    expect_tok("bad_crc", 48'h48000001AA89, e1);
    check_eq("bad_crc_const", {63'd0, bus.o_crc_err}, 64'd1);
    check_eq("bad_crc_arg_const", {32'd0, bus.o_arg}, 64'h1AA);
    send_bit(1'b1, 4);
    send_token(48'h400000000094, 4, 48);
    e1 = last_rise;
    expect_tok("bad_end", 48'h400000000094, e1);
    check_eq("bad_end_frm_const", {63'd0, bus.o_frame_err}, 64'd1);
    check_eq("bad_end_crc_const", {63'd0, bus.o_crc_err}, 64'd0);

    // Abort mid-token via receive enable, then a clean CMD17
    send_token(48'h400000000095, 4, 20);
    wait_cyc(4);
    check_eq("abort_busy_hi", {63'd0, bus.o_busy}, 64'd1);
    nv = n_valid;
    bus.i_rx_en = 1'b0;
    wait_cyc(1);
    check_eq("abort_busy_lo", {63'd0, bus.o_busy}, 64'd0);
    wait_cyc(3);
    bus.i_rx_en  = 1'b1;
    bus.i_sd_cmd = 1'b1;
    wait_cyc(4);
    send_token(48'h510000000055, 4, 48);
    e1 = last_rise;
    expect_tok("post_abort", 48'h510000000055, e1);
    check_eq("abort_pulses", 64'(n_valid - nv), 64'd1);

    // Randomized tokens, corruptions and clock ratios
    for (int k = 0; k < 24; k++) begin
      t    = make_token(6'($urandom_range(0, 63)), $urandom);
      mode = $urandom_range(0, 3);
      if (mode == 1) t[1 + $urandom_range(0, 6)] = ~t[1 + $urandom_range(0, 6)];
      if (mode == 2) t[0] = 1'b0;
      if (mode == 3) t[46] = 1'b0;
      h = $urandom_range(2, 6);
      repeat ($urandom_range(1, 3)) send_bit(1'b1, h);
      send_token(t, h, 48);
      e1 = last_rise;
      expect_tok($sformatf("rand%0d", k), t, e1);
    end

    // Asynchronous reset mid-token, then idle clocking with CMD high
    send_token(make_token(6'd17, $urandom), 4, 20);
    wait_cyc(4);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    wait_cyc(2);
    rst = 1'b0;
    bus.i_sd_cmd = 1'b1;
    wait_cyc(3);
    nv = n_valid;
    busy_seen = 1'b0;
    repeat (50) send_bit(1'b1, 3);
    wait_cyc(10);
    check_eq("idle_no_valid", 64'(n_valid - nv), 64'd0);
    check_eq("idle_no_busy", {63'd0, busy_seen}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_cmd_rx.md
Name: sd_cmd_rx

Overview:
- Receives host-to-card command tokens on the SD CMD line for the SD emulator.
- Sits directly downstream of the clock/reset generation in sd_emu_top: runs on a derived internal clock (clk_100 or clk_50) and uses the PLL reset.
- Oversamples the asynchronous SD_CLK and CMD pins, deserialises 48-bit command tokens, checks framing and CRC7, and presents the command index and argument to the command decoder with a one-cycle valid strobe.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchroniser stages on i_sd_clk and i_sd_cmd (minimum 2).

Ports:
- i_clk  input  1  internal oversampling clock; frequency must be at least 4x i_sd_clk.
- i_rst  input  1  reset, asynchronous, active-high (driven from PLL reset).
- i_sd_clk  input  1  raw SD host clock pin, asynchronous to i_clk.
- i_sd_cmd  input  1  raw SD CMD pin, asynchronous to i_clk; idles high.
- i_rx_en  input  1  receive enable; low while the card drives CMD (response phase).
- o_valid  output  1  one-cycle pulse when a complete 48-bit token has been received.
- o_cmd_index  output  6  token bits [45:40]; held until the next o_valid.
- o_arg  output  32  token bits [39:8]; held until the next o_valid.
- o_crc_err  output  1  CRC7 mismatch; qualified by o_valid, held with the fields.
- o_frame_err  output  1  transmission bit != 1 or end bit != 1; qualified by o_valid.
- o_busy  output  1  high from start-bit sample until o_valid.

Behaviour:
- Reset values: o_valid=0, o_cmd_index=0, o_arg=0, o_crc_err=0, o_frame_err=0, o_busy=0. Synchroniser flops reset to 1; FSM resets to IDLE; bit counter resets to 0.
- Synchronisation: i_sd_clk and i_sd_cmd each pass through SYNC_STAGES flops. A previous-value register on the synced clock yields a rising-edge strobe, sample_stb. The CMD value sampled is the synced CMD in the same cycle as sample_stb, so both paths have equal latency.
- IDLE:
  - sample_stb with i_rx_en=1 and cmd=0 → shift in the bit, set bit_cnt=1, go to RECV, set o_busy=1.
  - cmd=1 → stay in IDLE.
- RECV:
  - Each sample_stb shifts cmd into a 48-bit shift register (MSB first) and increments bit_cnt.
  - When the 48th bit is sampled (bit_cnt=47 → 48) → go to CHECK.
- CHECK (one cycle):
  - Compute CRC7 over token bits [47:8]: polynomial x^7+x^3+1, initial value 0.
  - o_crc_err = (CRC != token[7:1]).
  - o_frame_err = ~token[46] | ~token[0]. The start bit is 0 by construction.
  - Register o_cmd_index and o_arg.
  - Go to DONE.
- DONE (one cycle): o_valid=1, o_busy=0, then return to IDLE.
- Latency: o_valid is high exactly 2 i_clk cycles after the cycle in which sample_stb captured the end bit.
- o_valid pulses for every complete token, including errored ones. Fields and error flags update only at o_valid.
- CRC may be computed serially during RECV or in parallel in CHECK; the result is identical.
- i_rx_en low in RECV → abort to IDLE immediately: o_busy=0, no o_valid, outputs unchanged. i_rx_en is ignored in CHECK and DONE.
- A sample_stb arriving in CHECK or DONE is ignored; the ≥4x ratio guarantees none occurs.
- Back-to-back tokens: the next start bit is accepted on the first sample_stb after returning to IDLE.
- Asynchronous i_rst mid-frame clears everything immediately. After release, a partial frame's remaining bits (cmd=0) may be taken as a new start bit. This is acceptable; the resulting token fails CRC or framing.
- Glitch-free behaviour is required only for SD_CLK ≤ i_clk/4. No other timeout exists: a stalled SD_CLK holds RECV indefinitely.

Test Plan:
- CMD0: drive token 0x400000000095 at i_clk/8 → exactly one o_valid pulse 2 cycles after the end-bit strobe; o_cmd_index=0, o_arg=0x00000000, o_crc_err=0, o_frame_err=0.
- CMD8 then CMD17 back-to-back: 0x48000001AA87 followed by 0x510000000055 with one idle SD_CLK between them → two pulses. First: index=8, arg=0x000001AA. Second: index=17, arg=0. No errors on either.
- Bad CRC: 0x48000001AA89 → o_valid, index=8, arg=0x000001AA, o_crc_err=1, o_frame_err=0.
- Bad end bit: 0x400000000094 → o_valid, o_frame_err=1, o_crc_err=0.
- i_rx_en dropped after 20 bits of a CMD0 token, then restored and 0x510000000055 sent → no pulse for the aborted token; o_busy falls within 1 cycle; CMD17 is decoded correctly.
- Reset and idle:
  - Assert i_rst mid-token → all outputs 0 immediately.
  - Then toggle SD_CLK for 100 edges with cmd=1 → no o_valid, o_busy stays 0.
